// File: rtl/rep_string_seq.sv
// REP string-instruction address sequencer: walks ESI/EDI/ECX one element per handshake.
// Optional REPE/REPNE early exit on ZF is enabled by defining REP_STRING_SEQ_COND_TERM_EN.
module rep_string_seq #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              is_rep,
  input  logic [1:0]        size,
  input  logic              df,
  input  logic [ADDR_W-1:0] esi_in,
  input  logic [ADDR_W-1:0] edi_in,
  input  logic [CNT_W-1:0]  ecx_in,
  input  logic [1:0]        rep_cond,
  input  logic              zf_in,
  output logic              iter_valid,
  input  logic              iter_ready,
  output logic [ADDR_W-1:0] iter_src,
  output logic [ADDR_W-1:0] iter_dst,
  output logic              iter_last,
  output logic [ADDR_W-1:0] esi_out,
  output logic [ADDR_W-1:0] edi_out,
  output logic [CNT_W-1:0]  ecx_out,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic       is_rep;
    logic [1:0] size;
    logic       df;
    logic [1:0] rep_cond;
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] esi_q, esi_d, edi_q, edi_d;
  logic [CNT_W-1:0]  ecx_q, ecx_d;
  logic [ADDR_W-1:0] step;
  logic              last, term;

  assign step = ADDR_W'(1) << op_q.size;
  assign last = !op_q.is_rep || (ecx_q == CNT_W'(1));

`ifdef REP_STRING_SEQ_COND_TERM_EN
  // REPE stops on a mismatch, REPNE on a match; ECX/pointers still advance for that element
  assign term = op_q.is_rep &&
                ((op_q.rep_cond == 2'b10 && !zf_in) || (op_q.rep_cond == 2'b11 && zf_in));
`else
  logic unused_cond;
  assign term        = 1'b0;
  assign unused_cond = ^{op_q.rep_cond, zf_in};
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    esi_d   = esi_q;
    edi_d   = edi_q;
    ecx_d   = ecx_q;
    if (flush) begin
      // abort wins over any same-cycle start or handshake; registers keep their values
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_valid) begin
          op_d    = '{is_rep: is_rep, size: size, df: df, rep_cond: rep_cond};
          esi_d   = esi_in;
          edi_d   = edi_in;
          ecx_d   = ecx_in;
          state_d = (is_rep && ecx_in == '0) ? DONE : RUN;
        end
        RUN: if (iter_ready) begin
          esi_d = op_q.df ? esi_q - step : esi_q + step;
          edi_d = op_q.df ? edi_q - step : edi_q + step;
          if (op_q.is_rep) ecx_d = ecx_q - CNT_W'(1);
          if (last || term) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      esi_q   <= '0;
      edi_q   <= '0;
      ecx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      esi_q   <= esi_d;
      edi_q   <= edi_d;
      ecx_q   <= ecx_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign iter_valid  = (state_q == RUN);
  assign iter_last   = iter_valid && last;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign iter_src    = esi_q;
  assign iter_dst    = edi_q;
  assign esi_out     = esi_q;
  assign edi_out     = edi_q;
  assign ecx_out     = ecx_q;

endmodule

// File: tb/tb_rep_string_seq.sv
// Directed bench for rep_string_seq: vector table of whole operations plus flush/reset sequences.
module tb_rep_string_seq;

  logic        clk, rst, flush, start_valid, start_ready;
  logic        is_rep, df, zf_in, iter_valid, iter_ready, iter_last, done, busy;
  logic [1:0]  size, rep_cond;
  logic [31:0] esi_in, edi_in, ecx_in, iter_src, iter_dst, esi_out, edi_out, ecx_out;

  int errors = 0;
  int nchk   = 0;

  rep_string_seq #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .is_rep(is_rep), .size(size), .df(df),
    .esi_in(esi_in), .edi_in(edi_in), .ecx_in(ecx_in),
    .rep_cond(rep_cond), .zf_in(zf_in),
    .iter_valid(iter_valid), .iter_ready(iter_ready),
    .iter_src(iter_src), .iter_dst(iter_dst), .iter_last(iter_last),
    .esi_out(esi_out), .edi_out(edi_out), .ecx_out(ecx_out),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        is_rep;
    bit [1:0]  size;
    bit        df;
    bit [31:0] esi, edi, ecx;
    bit [1:0]  rep_cond;
    int        zf_k;      // handshake index that sees zf_in=0 (-1: never)
    int        stall;     // ready-low cycles before each handshake
    int        exp_n;
    bit [31:0] exp_esi, exp_edi, exp_ecx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge after the done cycle
  task automatic run_op(input vec_t v);
    int k, st;
    bit seen_done;
    logic [31:0] step, exp_src, exp_dst;
    step = 32'd1 << v.size;
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1'b1; is_rep = v.is_rep; size = v.size; df = v.df;
    esi_in = v.esi; edi_in = v.edi; ecx_in = v.ecx; rep_cond = v.rep_cond;
    iter_ready = 1'b0; zf_in = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    k = 0; st = 0; seen_done = 0;
    if (v.exp_n == 0) chk("zero_cnt_done_next", done, 1);
    else              chk("first_iter_valid", iter_valid, 1);
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1;
        chk("done_esi", esi_out, v.exp_esi);
        chk("done_edi", edi_out, v.exp_edi);
        chk("done_ecx", ecx_out, v.exp_ecx);
        chk("handshakes", k, v.exp_n);
        chk("no_start_in_done", start_ready, 0);
        chk("busy_in_done", busy, 1);
      end else if (iter_valid) begin
        exp_src = v.df ? v.esi - 32'(k) * step : v.esi + 32'(k) * step;
        exp_dst = v.df ? v.edi - 32'(k) * step : v.edi + 32'(k) * step;
        chk("iter_src", iter_src, exp_src);
        chk("iter_dst", iter_dst, exp_dst);
        chk("iter_last", iter_last, (!v.is_rep || (v.ecx - 32'(k) == 32'd1)) ? 1 : 0);
        zf_in = (k == v.zf_k) ? 1'b0 : 1'b1;
        if (st < v.stall) begin iter_ready = 1'b0; st++; end
        else begin iter_ready = 1'b1; st = 0; k++; end
      end else begin
        nchk++; errors++;
        $display("FAIL idle_mid_op: got iter_valid=0 done=0 expected activity");
        seen_done = 1;
      end
      @(negedge clk);
      iter_ready = 1'b0;
    end
    if (!seen_done) begin
      nchk++; errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", start_ready, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h2000, 32'd3, 2'b00, -1, 0, 3, 32'h100C, 32'h200C, 32'd0};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 32'h0, 32'h10, 32'd7, 2'b00, -1, 0, 1, 32'hFFFFFFFF, 32'hF, 32'd7};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 32'h55, 32'h66, 32'd0, 2'b00, -1, 0, 0, 32'h55, 32'h66, 32'd0};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 32'h100, 32'h8, 32'd2, 2'b00, -1, 0, 2, 32'hF0, 32'hFFFFFFF8, 32'd0};
    vecs[4] = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0, 32'd1, 2'b00, -1, 0, 1, 32'h0, 32'h2, 32'd0};
`ifdef REP_STRING_SEQ_COND_TERM_EN
    vecs[5] = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h20, 32'd5, 2'b10, 1, 0, 2, 32'h12, 32'h22, 32'd3};
`else
    vecs[5] = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h20, 32'd5, 2'b10, 1, 0, 5, 32'h15, 32'h25, 32'd0};
`endif
    vecs[6] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h80, 32'd0, 2'b00, -1, 0, 1, 32'h48, 32'h88, 32'd0};
    vecs[7] = '{1'b1, 2'd2, 1'b0, 32'h3000, 32'h4000, 32'd4, 2'b00, -1, 3, 4, 32'h3010, 32'h4010, 32'd0};

    rst = 1'b0; flush = 1'b0; start_valid = 1'b0; is_rep = 1'b0; size = 2'd0; df = 1'b0;
    esi_in = '0; edi_in = '0; ecx_in = '0; rep_cond = 2'b00; zf_in = 1'b1; iter_ready = 1'b0;
    #1;
    chk("rst_iter_valid", iter_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_esi", esi_out, 0);
    chk("rst_ecx", ecx_out, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // flush after the 2nd handshake, asserted together with a 3rd handshake
    start_valid = 1'b1; is_rep = 1'b1; size = 2'd0; df = 1'b0;
    esi_in = 32'h0; edi_in = 32'h100; ecx_in = 32'd5; rep_cond = 2'b00;
    @(negedge clk); start_valid = 1'b0; iter_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_flush_ecx", ecx_out, 3);
    chk("pre_flush_src", iter_src, 32'h2);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; iter_ready = 1'b0;
    chk("flush_idle", start_ready, 1);
    chk("flush_no_done", done, 0);
    chk("flush_busy", busy, 0);
    chk("flush_beats_hs", ecx_out, 3);
    run_op(vecs[0]);

    // flush beats a same-cycle start
    start_valid = 1'b1; flush = 1'b1; ecx_in = 32'd2;
    @(negedge clk); start_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", busy, 0);
    chk("flush_vs_start_ready", start_ready, 1);

    // asynchronous reset mid-RUN
    start_valid = 1'b1; is_rep = 1'b1; size = 2'd2; esi_in = 32'h500; edi_in = 32'h600; ecx_in = 32'd5;
    @(negedge clk); start_valid = 1'b0; iter_ready = 1'b1;
    @(negedge clk);
    chk("mid_run_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_iter_valid", iter_valid, 0);
    chk("arst_iter_last", iter_last, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_src", iter_src, 0);
    chk("arst_edi", edi_out, 0);
    chk("arst_ecx", ecx_out, 0);
    @(negedge clk); rst = 1'b1; iter_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", start_ready, 1);
    chk("post_rst_no_done", done, 0);
    run_op(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule
